pin_target: RTL and testbench
=============================

# pin_target

Emulated PIN-check device: the far end of the timing-measurement harness. It receives a fixed-length PIN candidate over UART, compares it byte by byte against a stored secret with an early-exit, per-byte delay, and returns a one-byte verdict over UART. This deliberately leaky comparison is the side channel that the harness times. The block is the on-board stand-in for the external device: its `RX` is driven by the harness device-side TX, its `TX` feeds the harness device-side RX, and its `RESET` is driven by the harness `RESET` output.

## Interface
- `PIN_LEN`, 16: candidate length in bytes.
- `PIN_VALUE`, 128'h3031_3233_3435_3637_3839_3031_3233_3435: secret. Byte 0 is bits [127:120].
- `BYTE_DELAY`, 1000: cycles spent per compared byte. Must be ≥ 1.
- `MAX_FAIL`, 3: number of failed attempts before lockout.
- `CLK` in 1: system clock.
- `RESET` in 1: synchronous, active-low reset.
- `RX` in 1: UART serial input from the harness.
- `TX` out 1: UART serial output to the harness.
- `GRANTED` out 1: sticky; set on a full match.
- `LOCKED` out 1: sticky; set once the fail count reaches `MAX_FAIL`.

## Operation
- Instantiates the codebase `uart_rx` and `uart_tx`. Their `rst` input is driven by `~RESET`.
- Reset values: `GRANTED`=0, `LOCKED`=0, `TX`=1 (idle), state=RECV, byte index=0, delay counter=0, fail count=0, candidate buffer=0.
- Reset mid-operation discards any partial candidate, in-progress comparison and pending response.
- **RECV**
  - Each `uart_rx` `valid` stores `data_out` at the current index and increments the index.
  - When the stored byte is the `PIN_LEN`-th: clear the index and go to COMPARE. If `LOCKED`, go to RESPOND with 0xEE instead.
- **COMPARE**
  - The delay counter counts 0..`BYTE_DELAY`-1.
  - On the last count, compare buffer[idx] with the secret byte idx.
  - Mismatch: verdict 0x00, go to RESPOND.
  - Match and idx=`PIN_LEN`-1: verdict 0x01, go to RESPOND.
  - Otherwise: increment idx and clear the counter.
- **RESPOND**
  - When `uart_tx` `rdy`=1, pulse `en` for one cycle with the verdict on `data_in`.
  - Verdict 0x01: set `GRANTED`.
  - Verdict 0x00: increment the fail count, saturating at `MAX_FAIL`. Reaching `MAX_FAIL` sets `LOCKED` in the same cycle.
  - Then return to RECV with index 0.
- Bytes arriving while in COMPARE or RESPOND are dropped and not buffered.
- A byte arriving in the same cycle as the RESPOND→RECV transition is dropped.
- Every byte value is data, including 0x09. Only `RESET` resets the block.
- `GRANTED` and `LOCKED` clear only on reset. A later failure does not clear `GRANTED`.
- The index and fail counter are sized by `$clog2` of their limits. No wrap is possible, because the index returns to 0 at `PIN_LEN`.

## Timing
- T0 is the cycle in which `valid` is high for the last candidate byte.
- Mismatch at byte m (0-based): the `en` pulse occurs at T0 + (m+1)·`BYTE_DELAY` + 1.
- Full match: the `en` pulse occurs at T0 + `PIN_LEN`·`BYTE_DELAY` + 1.
- Locked: the `en` pulse occurs at T0 + 1, with no compare delay.
- If `rdy`=0, the pulse stalls until `rdy`=1. `rdy` is normally 1, because TX is idle between attempts.
- `GRANTED`, `LOCKED` and the fail count update in the `en` cycle.
- Serial frame timing on `TX`/`RX` is that of `uart_tx`/`uart_rx`.

## Configuration
- `PIN_TARGET_CONSTANT_TIME_EN` defined:
  - COMPARE never exits early.
  - All `PIN_LEN` bytes are compared, and a mismatch flag is OR-accumulated.
  - The verdict is decided after the last byte.
  - Response latency is always T0 + `PIN_LEN`·`BYTE_DELAY` + 1, whether the candidate matches or not.
  - Lockout behaviour is unchanged.
- Undefined (default): early exit as in Operation. Latency leaks the matching prefix length.

## Test plan
Bench parameters: `BYTE_DELAY`=4, default `PIN_VALUE`. Frames are driven through a `uart_tx` model.
- Correct candidate "0123456789012345" → verdict 0x01 with `en` at T0+65; `GRANTED`=1; `LOCKED`=0.
- Wrong byte 0 ("X123…") → verdict 0x00 at T0+5. Wrong byte 4 ("0123X…") → verdict 0x00 at T0+21. Fail count is 2.
- Three wrong candidates → `LOCKED`=1 after the third response. Fourth candidate (correct) → verdict 0xEE at T0+1; `GRANTED` stays 0.
- 8 bytes sent, `RESET` low for 1 cycle, then a correct 16-byte candidate → verdict 0x01 at T0+65. Stale bytes are not used.
- Extra byte sent while in COMPARE → dropped. Next response is still correct, and the following candidate aligns from byte 0.
- With `PIN_TARGET_CONSTANT_TIME_EN`: wrong byte 0 and wrong byte 15 both → verdict 0x00 at T0+65.

Source files
------------

// File: rtl/pin_target.sv
`default_nettype none
// ============================================================================
//  Module      : pin_target (with uart_rx, uart_tx)
//  Description : Emulated PIN-check device. Receives a PIN_LEN-byte candidate
//                over UART, compares it against PIN_VALUE with a BYTE_DELAY
//                cycle cost per byte, and answers with a one-byte verdict:
//                0x01 granted, 0x00 denied, 0xEE locked out.
//                Optional macro PIN_TARGET_CONSTANT_TIME_EN removes the early
//                exit so the response latency no longer leaks the prefix.
//  Revision    : 1.0 - initial release
// ============================================================================

// 8N1 UART receiver: two-flop synchronised input, mid-bit sampling,
// one-cycle valid pulse when a frame with a good stop bit completes.
module uart_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       valid
);
    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [2:0]       bit_q,   bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q,  data_d;
    logic             valid_q, valid_d;
    logic [1:0]       sync_q,  sync_d;
    logic             rx_s;

    assign rx_s     = sync_q[1];
    assign data_out = data_q;
    assign valid    = valid_q;

    // Frame decoder: find start edge, verify start at mid-bit, shift data LSB first
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        sync_d  = {sync_q[0], rx};
        case (state_q)
            RX_IDLE: begin
                if (!rx_s) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    // A start bit that is high again at mid-bit was a glitch
                    state_d = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    if (rx_s) begin
                        valid_d = 1'b1;
                        data_d  = shift_q;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    // Receiver registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            sync_q  <= 2'b11;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            sync_q  <= sync_d;
        end
    end
endmodule

// 8N1 UART transmitter: rdy high while idle; en with rdy launches one frame.
module uart_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] data_in,
    output logic       tx,
    output logic       rdy
);
    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    tx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [2:0]       bit_q,   bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q,    tx_d;

    assign tx  = tx_q;
    assign rdy = (state_q == TX_IDLE);

    // Frame sequencer: the line level for the next bit is registered at each boundary
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        case (state_q)
            TX_IDLE: begin
                tx_d = 1'b1;
                if (en) begin
                    shift_d = data_in;
                    cnt_d   = '0;
                    tx_d    = 1'b0;
                    state_d = TX_START;
                end
            end
            TX_START: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = TX_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            TX_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = TX_STOP;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            TX_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = TX_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    // Transmitter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= TX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end
endmodule

module pin_target #(
    parameter int                   PIN_LEN      = 16,
    parameter logic [8*PIN_LEN-1:0] PIN_VALUE    = 128'h3031_3233_3435_3637_3839_3031_3233_3435,
    parameter int                   BYTE_DELAY   = 1000,
    parameter int                   MAX_FAIL     = 3,
    parameter int                   CLKS_PER_BIT = 16
) (
    input  logic CLK,
    input  logic RESET,
    input  logic RX,
    output logic TX,
    output logic GRANTED,
    output logic LOCKED
);
    localparam int IDX_W  = (PIN_LEN > 1)    ? $clog2(PIN_LEN)    : 1;
    localparam int DLY_W  = (BYTE_DELAY > 1) ? $clog2(BYTE_DELAY) : 1;
    localparam int FAIL_W = $clog2(MAX_FAIL + 1);

    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(PIN_LEN - 1);
    localparam logic [DLY_W-1:0]  DLY_LAST = DLY_W'(BYTE_DELAY - 1);
    localparam logic [FAIL_W-1:0] FAIL_MAX = FAIL_W'(MAX_FAIL);

    localparam logic [7:0] VERDICT_DENY   = 8'h00;
    localparam logic [7:0] VERDICT_GRANT  = 8'h01;
    localparam logic [7:0] VERDICT_LOCKED = 8'hEE;

    typedef enum logic [1:0] {
        ST_RECV    = 2'd0,
        ST_COMPARE = 2'd1,
        ST_RESPOND = 2'd2
    } pin_state_t;

    pin_state_t           state_q,   state_d;
    logic [IDX_W-1:0]     idx_q,     idx_d;
    logic [DLY_W-1:0]     dly_q,     dly_d;
    logic [FAIL_W-1:0]    fail_cnt_q, fail_cnt_d;
    logic [8*PIN_LEN-1:0] cand_q,    cand_d;
    logic [7:0]           verdict_q, verdict_d;
    logic                 granted_q, granted_d;
    logic                 locked_q,  locked_d;
`ifdef PIN_TARGET_CONSTANT_TIME_EN
    logic                 mism_q,    mism_d;
`endif

    logic                 uart_rst;
    logic [7:0]           rx_data;
    logic                 rx_valid;
    logic                 tx_rdy;
    logic                 tx_en;
    logic [7:0]           tx_data;
    logic [7:0]           cand_byte;
    logic [7:0]           secret_byte;
    logic                 byte_mismatch;
    logic [FAIL_W-1:0]    fail_next;

    assign uart_rst = ~RESET;
    assign GRANTED  = granted_q;
    assign LOCKED   = locked_q;

    // The response byte leaves in the first RESPOND cycle the transmitter can take it
    assign tx_en   = (state_q == ST_RESPOND) && tx_rdy;
    assign tx_data = verdict_q;

    uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk      (CLK),
        .rst      (uart_rst),
        .rx       (RX),
        .data_out (rx_data),
        .valid    (rx_valid)
    );

    uart_tx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tx (
        .clk     (CLK),
        .rst     (uart_rst),
        .en      (tx_en),
        .data_in (tx_data),
        .tx      (TX),
        .rdy     (tx_rdy)
    );

    // Byte idx of the candidate and of the secret; byte 0 sits in the top bits
    always_comb begin
        cand_byte     = cand_q[8*(PIN_LEN-1-int'(idx_q)) +: 8];
        secret_byte   = PIN_VALUE[8*(PIN_LEN-1-int'(idx_q)) +: 8];
        byte_mismatch = (cand_byte != secret_byte);
        fail_next     = (fail_cnt_q == FAIL_MAX) ? fail_cnt_q : fail_cnt_q + 1'b1;
    end

    // Receive / compare / respond sequencing
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        dly_d      = dly_q;
        fail_cnt_d = fail_cnt_q;
        cand_d     = cand_q;
        verdict_d  = verdict_q;
        granted_d  = granted_q;
        locked_d   = locked_q;
`ifdef PIN_TARGET_CONSTANT_TIME_EN
        mism_d     = mism_q;
`endif
        case (state_q)
            ST_RECV: begin
                if (rx_valid) begin
                    cand_d[8*(PIN_LEN-1-int'(idx_q)) +: 8] = rx_data;
                    if (idx_q == IDX_LAST) begin
                        idx_d = '0;
                        dly_d = '0;
`ifdef PIN_TARGET_CONSTANT_TIME_EN
                        mism_d = 1'b0;
`endif
                        if (locked_q) begin
                            verdict_d = VERDICT_LOCKED;
                            state_d   = ST_RESPOND;
                        end else begin
                            state_d   = ST_COMPARE;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_COMPARE: begin
                if (dly_q == DLY_LAST) begin
                    dly_d = '0;
`ifdef PIN_TARGET_CONSTANT_TIME_EN
                    // Walk every byte; the verdict only depends on the accumulated flag
                    if (idx_q == IDX_LAST) begin
                        verdict_d = (mism_q | byte_mismatch) ? VERDICT_DENY : VERDICT_GRANT;
                        idx_d     = '0;
                        state_d   = ST_RESPOND;
                    end else begin
                        mism_d = mism_q | byte_mismatch;
                        idx_d  = idx_q + 1'b1;
                    end
`else
                    // Early exit on the first differing byte: latency reveals the prefix
                    if (byte_mismatch) begin
                        verdict_d = VERDICT_DENY;
                        idx_d     = '0;
                        state_d   = ST_RESPOND;
                    end else if (idx_q == IDX_LAST) begin
                        verdict_d = VERDICT_GRANT;
                        idx_d     = '0;
                        state_d   = ST_RESPOND;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
`endif
                end else begin
                    dly_d = dly_q + 1'b1;
                end
            end
            ST_RESPOND: begin
                if (tx_rdy) begin
                    if (verdict_q == VERDICT_GRANT) begin
                        granted_d = 1'b1;
                    end
                    if (verdict_q == VERDICT_DENY) begin
                        fail_cnt_d = fail_next;
                        if (fail_next == FAIL_MAX) begin
                            locked_d = 1'b1;
                        end
                    end
                    idx_d   = '0;
                    state_d = ST_RECV;
                end
            end
            default: state_d = ST_RECV;
        endcase
    end

    // Control registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q    <= ST_RECV;
            idx_q      <= '0;
            dly_q      <= '0;
            fail_cnt_q <= '0;
            cand_q     <= '0;
            verdict_q  <= '0;
            granted_q  <= 1'b0;
            locked_q   <= 1'b0;
`ifdef PIN_TARGET_CONSTANT_TIME_EN
            mism_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            dly_q      <= dly_d;
            fail_cnt_q <= fail_cnt_d;
            cand_q     <= cand_d;
            verdict_q  <= verdict_d;
            granted_q  <= granted_d;
            locked_q   <= locked_d;
`ifdef PIN_TARGET_CONSTANT_TIME_EN
            mism_q     <= mism_d;
`endif
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_pin_target.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pin_target
//  Description : Self-checking bench for pin_target. Drives UART frames,
//                decodes the serial verdict, and compares verdict, latency
//                from the last received byte, and sticky flags against a
//                prefix-matching reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pin_target;
    localparam int CPB      = 4;
    localparam int BD       = 4;
    localparam int PLEN     = 16;
    localparam int MAXF     = 3;
    localparam logic [127:0] PIN_VAL = 128'h3031_3233_3435_3637_3839_3031_3233_3435;
`ifdef PIN_TARGET_CONSTANT_TIME_EN
    localparam bit CT_MODE = 1'b1;
`else
    localparam bit CT_MODE = 1'b0;
`endif

    logic clk;
    logic rst_n;
    logic rx_line;
    logic tx_line;
    logic granted;
    logic locked;

    int n_vec;
    int n_err;
    int cyc;

    int         valid_cyc_q[$];
    int         en_cyc_q[$];
    logic [7:0] en_dat_q[$];
    logic [7:0] ser_q[$];
    logic [7:0] ser_b;

    // Reference model state
    bit m_granted;
    bit m_locked;
    int m_fails;

    pin_target #(
        .PIN_LEN      (PLEN),
        .PIN_VALUE    (PIN_VAL),
        .BYTE_DELAY   (BD),
        .MAX_FAIL     (MAXF),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .CLK     (clk),
        .RESET   (rst_n),
        .RX      (rx_line),
        .TX      (tx_line),
        .GRANTED (granted),
        .LOCKED  (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event timestamps for latency measurement
    always @(negedge clk) begin
        if (dut.rx_valid) valid_cyc_q.push_back(cyc);
        if (dut.tx_en) begin
            en_cyc_q.push_back(cyc);
            en_dat_q.push_back(dut.tx_data);
        end
    end

    // Serial decoder for the verdict frame on TX
    initial begin
        forever begin
            @(negedge tx_line);
            repeat (CPB / 2) @(posedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(posedge clk);
                #1 ser_b[i] = tx_line;
            end
            repeat (CPB) @(posedge clk);
            ser_q.push_back(ser_b);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_granted = 1'b0;
        m_locked  = 1'b0;
        m_fails   = 0;
    endtask

    // Verdict and latency from first differing byte; updates sticky model state
    task automatic model(input logic [127:0] cand, output int v, output int lat);
        int first;
        first = -1;
        if (m_locked) begin
            v   = 8'hEE;
            lat = 1;
            return;
        end
        for (int i = 0; i < PLEN; i++) begin
            if (first < 0 && cand[8*(PLEN-1-i) +: 8] != PIN_VAL[8*(PLEN-1-i) +: 8]) first = i;
        end
        if (first < 0) begin
            v   = 8'h01;
            lat = PLEN * BD + 1;
            m_granted = 1'b1;
        end else begin
            v   = 8'h00;
            lat = CT_MODE ? (PLEN * BD + 1) : ((first + 1) * BD + 1);
            if (m_fails < MAXF) m_fails++;
            if (m_fails == MAXF) m_locked = 1'b1;
        end
    endtask

    task automatic send_bit(input logic v);
        rx_line = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(1'b1);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        repeat (n) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    function automatic logic [127:0] with_byte(input logic [127:0] base, input int pos, input logic [7:0] b);
        logic [127:0] r;
        r = base;
        r[8*(PLEN-1-pos) +: 8] = b;
        return r;
    endfunction

    task automatic attempt(input logic [127:0] cand, input bit extra, input string tag);
        int exp_v;
        int exp_lat;
        int t;
        model(cand, exp_v, exp_lat);
        valid_cyc_q.delete();
        en_cyc_q.delete();
        en_dat_q.delete();
        ser_q.delete();
        for (int i = 0; i < PLEN; i++) send_byte(cand[8*(PLEN-1-i) +: 8]);
        if (extra) send_byte(8'h5A);
        t = 0;
        while (en_cyc_q.size() == 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (en_cyc_q.size() == 0) begin
            chk({tag, ".timeout"}, 32'd0, 32'd1);
        end else begin
            chk({tag, ".verdict"}, 32'(en_dat_q[0]), 32'(exp_v));
            if (valid_cyc_q.size() < PLEN)
                chk({tag, ".rxcount"}, 32'(valid_cyc_q.size()), 32'(PLEN));
            else
                chk({tag, ".latency"}, 32'(en_cyc_q[0] - valid_cyc_q[PLEN-1]), 32'(exp_lat));
        end
        repeat (12 * CPB) @(negedge clk);
        if (ser_q.size() == 0) chk({tag, ".serial_missing"}, 32'd0, 32'd1);
        else                   chk({tag, ".serial"}, 32'(ser_q[0]), 32'(exp_v));
        chk({tag, ".granted"}, 32'(granted), 32'(m_granted));
        chk({tag, ".locked"},  32'(locked),  32'(m_locked));
        chk({tag, ".fails"},   32'(dut.fail_cnt_q), 32'(m_fails));
    endtask

    initial begin
        logic [127:0] pin;
        logic [127:0] cand;
        logic [7:0]   b;
        int           pos;
        n_vec   = 0;
        n_err   = 0;
        cyc     = 0;
        pin     = PIN_VAL;
        rst_n   = 1'b0;
        rx_line = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset.tx",      32'(tx_line), 32'd1);
        chk("reset.granted", 32'(granted), 32'd0);
        chk("reset.locked",  32'(locked),  32'd0);
        chk("reset.fails",   32'(dut.fail_cnt_q), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Correct candidate
        attempt(pin, 1'b0, "match");

        // Wrong byte 0, wrong byte 4, wrong byte 15 -> lockout, then locked reply
        do_reset(1);
        attempt(with_byte(pin, 0, 8'h58), 1'b0, "wrong0");
        attempt(with_byte(pin, 4, 8'h58), 1'b0, "wrong4");
        attempt(with_byte(pin, 15, 8'h58), 1'b0, "wrong15");
        attempt(pin, 1'b0, "locked");

        // Partial candidate discarded by reset
        do_reset(1);
        for (int i = 0; i < 8; i++) send_byte(8'h39);
        do_reset(1);
        attempt(pin, 1'b0, "after_reset");

        // Stray byte during comparison is dropped; next candidate aligns
        attempt(pin, 1'b1, "extra");
        attempt(with_byte(pin, 2, 8'h09), 1'b0, "aligned");

        // Randomised candidates
        for (int k = 0; k < 12; k++) begin
            if ($urandom_range(0, 3) == 0) do_reset(1 + $urandom_range(0, 2));
            case ($urandom_range(0, 2))
                0: cand = pin;
                1: begin
                    pos = $urandom_range(0, PLEN - 1);
                    b   = 8'($urandom_range(0, 255));
                    if (b == pin[8*(PLEN-1-pos) +: 8]) b = b ^ 8'h40;
                    cand = with_byte(pin, pos, b);
                end
                default: cand = {$urandom, $urandom, $urandom, $urandom};
            endcase
            attempt(cand, 1'b0, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
